param_register_file: RTL
========================

// Module: param_register_file
// PURPOSE
//  Parametrised successor to the fixed 4+4 register file: NGP general-purpose plus NSCR scratch registers, W bits each.
//  - One shared input bus I. All enabled registers perform the same FunSel operation on a Clock rising edge.
//  - Two independent read ports, OutA and OutB. Each is combinational or registered, chosen by OUT_REG.
//  - Sits between the datapath input mux and the ALU operand buses.
// PARAMETERS
//  W       16  register width in bits; must be even and >= 4
//  NGP      4  number of general-purpose registers R1..R(NGP)
//  NSCR     4  number of scratch registers S1..S(NSCR)
//  OUT_REG  0  0: read ports are combinational; 1: read ports are registered (1-cycle latency)
//  SW      $clog2(NGP+NSCR)  width of the read-select signals (derived; not overridden)
// PORTS
//  Clock    in   1        rising-edge clock
//  Reset    in   1        asynchronous, active-low reset
//  I        in   W        input data bus
//  FunSel   in   3        operation code applied to every enabled register
//  RegSel   in   NGP      active-low enables; bit NGP-1 = R1 ... bit 0 = R(NGP)
//  ScrSel   in   NSCR     active-low enables; bit NSCR-1 = S1 ... bit 0 = S(NSCR)
//  OutASel  in   SW       read select A: 0..NGP-1 = R1..R(NGP); NGP..NGP+NSCR-1 = S1..S(NSCR)
//  OutBSel  in   SW       read select B; same encoding as OutASel
//  OutA     out  W        read port A
//  OutB     out  W        read port B
// BEHAVIOUR
//  - Reset low, at any time: all registers go to 0 immediately. If OUT_REG=1, OutA and OutB also go to 0.
//    No operation is applied on the edge where Reset is low. Release takes effect on the next rising edge.
//  - Per register, on a rising edge with enable low (H = W/2):
//    000 DEC   Q <= Q-1, mod 2^W
//    001 INC   Q <= Q+1, mod 2^W
//    010 LOAD  Q <= I
//    011 CLR   Q <= 0
//    100 LLZ   Q <= {H'b0, I[H-1:0]}
//    101 LLK   Q <= {Q[W-1:H], I[H-1:0]}
//    110 LHK   Q <= {I[H-1:0], Q[H-1:0]}
//    111 SEXT  Q <= {{H{I[H-1]}}, I[H-1:0]}
//  - Enable high: register holds. RegSel and ScrSel all-high: no state change.
//  - Any number of registers may be enabled at once; each applies FunSel to its own Q independently.
//  - Wrap-around: DEC of 0 gives all-ones; INC of all-ones gives 0.
//  - Read mux: a select value >= NGP+NSCR reads as 0 on that port.
//  - OUT_REG=0: OutA/OutB follow the selects and register contents combinationally.
//    Reading a register written on edge k shows the new value just after edge k.
//  - OUT_REG=1: on each edge, OutX <= mux(OutXSel, pre-edge contents).
//    A value written on edge k therefore appears on OutX at edge k+1.
//  - OutA and OutB are independent; both may select the same register.
// CONFIGURATION
//  - REGFILE_SATURATE_EN defined: INC of all-ones holds all-ones; DEC of 0 holds 0. Other ops unchanged.
//  - REGFILE_SATURATE_EN undefined: INC and DEC wrap modulo 2^W.
// TESTING (W=16, NGP=4, NSCR=4 unless noted)
//  1. Reset: drive Reset=0 mid-run after loading all registers.
//     -> every select reads 0000 on both ports; in OUT_REG=1, OutA=OutB=0 immediately.
//  2. Broadcast load: I=1234, FunSel=010, RegSel=0000, ScrSel=1111, one edge.
//     -> R1..R4 read 1234; S1..S4 read 0000.
//  3. Wrap, macro undefined: S2=FFFF, FunSel=001 -> 0000; then FunSel=000 -> FFFF.
//     With REGFILE_SATURATE_EN: FFFF stays FFFF on INC; 0000 stays 0000 on DEC.
//  4. Half ops on R3=ABCD, I=0x1280:
//     LLZ -> 0080; LLK from ABCD -> AB80; LHK from ABCD -> 80CD; SEXT -> FF80.
//  5. Latency, OUT_REG=1: load R1=5A5A on edge k with OutASel=0.
//     -> OutA shows the old value after edge k and 5A5A after edge k+1.
//  6. Out-of-range select, NGP=3, NSCR=2 (SW=3): OutASel=5,6,7 -> OutA=0.
//     OutBSel=4 -> S2 value; the two ports update independently in the same cycle.

Source files
------------

// File: rtl/param_register_file_if.sv
// Register-file access bus: shared write data/op/enables, two read selects and two read data ports.
// The master drives writes and selects; the register file answers on OutA/OutB.
interface param_register_file_if #(
  parameter int W    = 16,
  parameter int NGP  = 4,
  parameter int NSCR = 4
);
  localparam int SW = $clog2(NGP + NSCR);

  logic [W-1:0]    I;
  logic [2:0]      FunSel;
  logic [NGP-1:0]  RegSel;
  logic [NSCR-1:0] ScrSel;
  logic [SW-1:0]   OutASel;
  logic [SW-1:0]   OutBSel;
  logic [W-1:0]    OutA;
  logic [W-1:0]    OutB;

  modport master (
    output I, FunSel, RegSel, ScrSel, OutASel, OutBSel,
    input  OutA, OutB
  );

  modport slave (
    input  I, FunSel, RegSel, ScrSel, OutASel, OutBSel,
    output OutA, OutB
  );
endinterface

// File: rtl/param_register_file.sv
// NGP general-purpose + NSCR scratch registers, shared-op write, two read ports (0 or 1 cycle via OUT_REG); no backpressure.
// Define REGFILE_SATURATE_EN to make INC/DEC saturate instead of wrapping.
module param_register_file #(
  parameter int W       = 16,
  parameter int NGP     = 4,
  parameter int NSCR    = 4,
  parameter int OUT_REG = 0
) (
  input logic                  Clock,
  input logic                  Reset,
  param_register_file_if.slave bus
);
  localparam int SW   = $clog2(NGP + NSCR);
  localparam int NREG = NGP + NSCR;
  localparam int H    = W / 2;
  localparam logic [W-1:0] LP_ONE = W'(1);

  logic [W-1:0]    r_regs [NREG];
  logic [W-1:0]    w_next [NREG];
  logic [NREG-1:0] w_en;
  logic [W-1:0]    w_rd_a;
  logic [W-1:0]    w_rd_b;

  function automatic logic [W-1:0] f_next(input logic [W-1:0] q,
                                          input logic [W-1:0] d,
                                          input logic [2:0]   op);
    f_next = q;
    case (op)
      3'b000: begin
`ifdef REGFILE_SATURATE_EN
        f_next = (q == '0) ? q : q - LP_ONE;
`else
        f_next = q - LP_ONE;
`endif
      end
      3'b001: begin
`ifdef REGFILE_SATURATE_EN
        f_next = (q == '1) ? q : q + LP_ONE;
`else
        f_next = q + LP_ONE;
`endif
      end
      3'b010:  f_next = d;
      3'b011:  f_next = '0;
      3'b100:  f_next = {{H{1'b0}}, d[H-1:0]};
      3'b101:  f_next = {q[W-1:H], d[H-1:0]};
      3'b110:  f_next = {d[H-1:0], q[H-1:0]};
      default: f_next = {{H{d[H-1]}}, d[H-1:0]};
    endcase
  endfunction

  // Enables are active-low and MSB-first: RegSel[NGP-1] is R1, ScrSel[NSCR-1] is S1.
  always_comb begin
    w_en = '0;
    for (int k = 0; k < NGP; k++)  w_en[k]       = ~bus.RegSel[NGP-1-k];
    for (int k = 0; k < NSCR; k++) w_en[NGP + k] = ~bus.ScrSel[NSCR-1-k];
  end

  always_comb begin
    for (int k = 0; k < NREG; k++) w_next[k] = f_next(r_regs[k], bus.I, bus.FunSel);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (w_en[k]) r_regs[k] <= w_next[k];
      end
    end
  end

  // Unmatched selects (>= NREG) fall through to the zero default.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    for (int k = 0; k < NREG; k++) begin
      if (bus.OutASel == SW'(k)) w_rd_a = r_regs[k];
      if (bus.OutBSel == SW'(k)) w_rd_b = r_regs[k];
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [W-1:0] r_out_a;
    logic [W-1:0] r_out_b;

    always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
        r_out_a <= '0;
        r_out_b <= '0;
      end else begin
        r_out_a <= w_rd_a;
        r_out_b <= w_rd_b;
      end
    end

    assign bus.OutA = r_out_a;
    assign bus.OutB = r_out_b;
  end else begin : g_out_comb
    assign bus.OutA = w_rd_a;
    assign bus.OutB = w_rd_b;
  end
endmodule
